// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_arb_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned SRC_W    = 3;

    // Conventional source slots on the writeback bus
    localparam logic [SRC_W-1:0] SRC_ALU    = 3'd0;
    localparam logic [SRC_W-1:0] SRC_LOAD   = 3'd1;
    localparam logic [SRC_W-1:0] SRC_MULDIV = 3'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo NREQ and
// returns the first requester found, as a one-hot vector and as an index.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    // First valid requester after the pointer wins
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = ptr;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(ptr) + off) % NREQ;
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant_idx      = idx[PW-1:0];
                grant[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares the single RF write port among NREQ
// sources with round-robin priority. Outputs are registered; the RF captures
// them on the following negedge.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32,
    parameter int unsigned CW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               RegWrite,
    output logic [AW-1:0]      RdAddr,
    output logic [DW-1:0]      RdData,
    output logic [SRC_W-1:0]   wb_src,
    output logic [CW-1:0]      conflict_cnt
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    logic             grant_any;
    logic             multi_valid;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;

    logic             regwrite_d;
    logic [AW-1:0]    rdaddr_d;
    logic [DW-1:0]    rddata_d;
    logic [SRC_W-1:0] wb_src_d;
    logic [CW-1:0]    conflict_cnt_d;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // No grant is offered while reset is held, so nothing handshakes then
    assign req_ready = rst_n ? grant : '0;

    // Two or more bits set: clearing the lowest set bit leaves something
    assign multi_valid = |(req_valid & (req_valid - NREQ'(1)));

    // Mux the winning requester's address and data
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state: hold write info when idle, capture the winner on a transfer
    always_comb begin
        regwrite_d     = 1'b0;
        rdaddr_d       = RdAddr;
        rddata_d       = RdData;
        wb_src_d       = wb_src;
        rr_ptr_d       = rr_ptr_q;
        conflict_cnt_d = conflict_cnt;
        if (grant_any) begin
            // R0 writes complete the handshake but never reach the RF
            regwrite_d = (win_addr != AW'(REG_ZERO));
            rdaddr_d   = win_addr;
            rddata_d   = win_data;
            wb_src_d   = SRC_W'(grant_idx);
            rr_ptr_d   = grant_idx;
        end
        if (multi_valid && (conflict_cnt != '1)) begin
            conflict_cnt_d = conflict_cnt + CW'(1);
        end
    end

    // State and registered RF write port; pointer resets so requester 0 goes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite     <= 1'b0;
            RdAddr       <= '0;
            RdData       <= '0;
            wb_src       <= SRC_ALU;
            rr_ptr_q     <= PW'(NREQ - 1);
            conflict_cnt <= '0;
        end else begin
            RegWrite     <= regwrite_d;
            RdAddr       <= rdaddr_d;
            RdData       <= rddata_d;
            wb_src       <= wb_src_d;
            rr_ptr_q     <= rr_ptr_d;
            conflict_cnt <= conflict_cnt_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default build plus a CW=4 build
// sharing the same inputs for the counter saturation case).
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    logic [NREQ-1:0]    req_ready;
    logic               RegWrite;
    logic [AW-1:0]      RdAddr;
    logic [DW-1:0]      RdData;
    logic [SRC_W-1:0]   wb_src;
    logic [CW-1:0]      conflict_cnt;

    logic [NREQ-1:0]    s_req_ready;
    logic               s_RegWrite;
    logic [AW-1:0]      s_RdAddr;
    logic [DW-1:0]      s_RdData;
    logic [SRC_W-1:0]   s_wb_src;
    logic [3:0]         s_conflict_cnt;

    int checks;
    int failures;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .RegWrite     (RegWrite),
        .RdAddr       (RdAddr),
        .RdData       (RdData),
        .wb_src       (wb_src),
        .conflict_cnt (conflict_cnt)
    );

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (s_req_ready),
        .RegWrite     (s_RegWrite),
        .RdAddr       (s_RdAddr),
        .RdData       (s_RdData),
        .wb_src       (s_wb_src),
        .conflict_cnt (s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h0000_0011);
        set_req(1, 5'd2, 32'h0000_0022);
        set_req(2, 5'd3, 32'h0000_0033);
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++; $display("FAIL reset_regwrite: got %b required 0", RegWrite);
        end
        checks++;
        if (req_ready !== 3'b000) begin
            failures++; $display("FAIL reset_ready: got %b required 000", req_ready);
        end
        checks++;
        if (conflict_cnt !== 16'd0 || RdAddr !== 5'd0 || RdData !== 32'd0 || wb_src !== 3'd0)
        begin
            failures++;
            $display("FAIL reset_regs: got cnt=%0d addr=%0d data=%h src=%0d required all 0",
                     conflict_cnt, RdAddr, RdData, wb_src);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            failures++; $display("FAIL reset_first_grant: got %b required 001", req_ready);
        end
        tick();
        checks++;
        if (wb_src !== SRC_ALU || RegWrite !== 1'b1 || RdData !== 32'h0000_0011) begin
            failures++;
            $display("FAIL reset_first_write: got src=%0d we=%b data=%h required 0 1 00000011",
                     wb_src, RegWrite, RdData);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 5'd8, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            failures++; $display("FAIL single_ready: got %b required 010", req_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || RdAddr !== 5'd8 || RdData !== 32'hDEAD_BEEF
            || wb_src !== SRC_LOAD) begin
            failures++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h src=%0d required 1 8 deadbeef 1",
                     RegWrite, RdAddr, RdData, wb_src);
        end
        req_valid = '0;
        tick();
        checks++;
        if (RegWrite !== 1'b0 || RdAddr !== 5'd8 || RdData !== 32'hDEAD_BEEF
            || wb_src !== SRC_LOAD) begin
            failures++;
            $display("FAIL single_idle_hold: got we=%b addr=%0d data=%h src=%0d required 0 8 deadbeef 1",
                     RegWrite, RdAddr, RdData, wb_src);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_src [6];
        logic [2:0] exp_rdy [6];
        exp_src = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        set_req(0, 5'd4, 32'hA000_0000);
        set_req(1, 5'd5, 32'hB000_0001);
        set_req(2, 5'd6, 32'hC000_0002);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_ready !== exp_rdy[k]) begin
                failures++;
                $display("FAIL rr_ready[%0d]: got %b required %b", k, req_ready, exp_rdy[k]);
            end
            tick();
            checks++;
            if (wb_src !== exp_src[k] || RdAddr !== 5'(4 + exp_src[k])) begin
                failures++;
                $display("FAIL rr_src[%0d]: got src=%0d addr=%0d required src=%0d addr=%0d",
                         k, wb_src, RdAddr, exp_src[k], 4 + exp_src[k]);
            end
        end
        req_valid = '0;
        tick();
        checks++;
        if (conflict_cnt !== 16'd6) begin
            failures++; $display("FAIL rr_conflict_cnt: got %0d required 6", conflict_cnt);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        set_req(0, 5'd10, 32'h0000_0100);
        set_req(1, 5'd10, 32'h0000_0101);
        set_req(2, 5'd10, 32'h0000_0102);
        // Only 0 and 1 first, then 2 joins and must be next after 1
        req_valid = 3'b011;
        tick();
        tick();
        req_valid = 3'b111;
        tick();
        checks++;
        if (wb_src !== SRC_MULDIV || RdData !== 32'h0000_0102) begin
            failures++;
            $display("FAIL fair_late_join: got src=%0d data=%h required 2 00000102",
                     wb_src, RdData);
        end
        tick();
        checks++;
        if (wb_src !== SRC_ALU || RdAddr !== 5'd10 || RdData !== 32'h0000_0100) begin
            failures++;
            $display("FAIL fair_wrap: got src=%0d data=%h required 0 00000100", wb_src, RdData);
        end
        req_valid = '0;
    endtask

    task automatic test_r0();
        do_reset();
        set_req(0, 5'd3, 32'h0000_5555);
        set_req(2, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b100;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            failures++; $display("FAIL r0_ready: got %b required 100", req_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || wb_src !== SRC_MULDIV || RdAddr !== 5'd0
            || RdData !== 32'h0000_1234) begin
            failures++;
            $display("FAIL r0_write: got we=%b src=%0d addr=%0d data=%h required 0 2 0 00001234",
                     RegWrite, wb_src, RdAddr, RdData);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 5'd7, 32'h7777_0000);
        set_req(1, 5'd8, 32'h8888_0000);
        set_req(2, 5'd9, 32'h9999_0000);
        req_valid = 3'b111;
        tick();
        tick();
        // Grants so far 0 then 1; pointer now sits at 1
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b0 || conflict_cnt !== 16'd0 || req_ready !== 3'b000) begin
            failures++;
            $display("FAIL midreset_async: got we=%b cnt=%0d rdy=%b required 0 0 000",
                     RegWrite, conflict_cnt, req_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            failures++; $display("FAIL midreset_ptr: got %b required 001", req_ready);
        end
        tick();
        checks++;
        if (wb_src !== SRC_ALU || RdData !== 32'h7777_0000 || RegWrite !== 1'b1) begin
            failures++;
            $display("FAIL midreset_retry: got src=%0d data=%h we=%b required 0 77770000 1",
                     wb_src, RdData, RegWrite);
        end
        req_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        set_req(0, 5'd1, 32'h1);
        set_req(1, 5'd2, 32'h2);
        set_req(2, 5'd3, 32'h3);
        req_valid = 3'b110;
        for (int k = 0; k < 14; k++) tick();
        checks++;
        if (s_conflict_cnt !== 4'd14) begin
            failures++; $display("FAIL sat_below: got %0d required 14", s_conflict_cnt);
        end
        for (int k = 0; k < 6; k++) tick();
        req_valid = '0;
        tick();
        checks++;
        if (s_conflict_cnt !== 4'd15) begin
            failures++; $display("FAIL sat_stick: got %0d required 15", s_conflict_cnt);
        end
        checks++;
        if (conflict_cnt !== 16'd20) begin
            failures++; $display("FAIL sat_wide_cnt: got %0d required 20", conflict_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_r0();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
